// File: rtl/dram_ctrl_pkg.sv
// Shared definitions for the Mackerel 68000 DRAM controller.
//   - controller state encoding
//   - default timing parameters (refresh interval, precharge, refresh RAS width)
//   - row/column bit positions within the CPU word address ADDR_IN[23:1]
package dram_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_A_RAS   = 3'd1,
    ST_A_COL   = 3'd2,
    ST_A_CAS   = 3'd3,
    ST_REF_CAS = 3'd4,
    ST_REF_RAS = 3'd5,
    ST_PRE     = 3'd6
  } state_t;

  // 15.6 us between refreshes at 50 MHz
  localparam int DEF_REFRESH_INTERVAL = 780;
  localparam int DEF_T_RP             = 2;
  localparam int DEF_T_RAS_REF        = 3;

  localparam int DRAM_ADDR_W = 11;

  // Row and column slices of the CPU word address (bit 23 is not decoded)
  localparam int ROW_MSB = 22;
  localparam int ROW_LSB = 12;
  localparam int COL_MSB = 11;
  localparam int COL_LSB = 1;

endpackage

// File: rtl/dram_refresh_timer.sv
// Periodic refresh request generator.
//   clk    : system clock
//   rst    : synchronous reset, active-high
//   clear  : refresh is starting this edge; drops the pending request
//   due    : a refresh is owed (pending, or the interval expires this edge)
// The counter runs freely from 0 and wraps after REFRESH_INTERVAL clocks,
// latching a pending request on each wrap.
module dram_refresh_timer
  import dram_ctrl_pkg::*;
#(
  parameter int REFRESH_INTERVAL = DEF_REFRESH_INTERVAL
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic due
);

  localparam int CW = $clog2(REFRESH_INTERVAL + 1);

  logic [CW-1:0] count_q;
  logic          pending_q;
  logic          wrap;

  assign wrap = (count_q == CW'(REFRESH_INTERVAL - 1));

  // Including the wrap edge lets a refresh beat an access request that is
  // sampled on the very edge the interval expires.
  assign due = pending_q | wrap;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      count_q <= wrap ? '0 : count_q + CW'(1);
      if (clear) begin
        pending_q <= 1'b0;
      end else if (wrap) begin
        pending_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/dram_ctrl.sv
// Asynchronous DRAM controller: 68000 bus cycles to RAS/CAS sequencing with
// a multiplexed 11-bit row/column address, DTACK generation and periodic
// CAS-before-RAS refresh. All strobes are active-low.
//   CLK_ALT    : system clock, rising edge
//   RST        : synchronous reset, active-high
//   CS, AS     : DRAM chip select, 68000 address strobe
//   LDS, UDS   : lower / upper data strobes (byte lanes D7:0 / D15:8)
//   RW         : read/write, routed to the DRAM externally; no logic here
//   ADDR_IN    : CPU word address bits 23:1
//   ADDR_OUT   : multiplexed DRAM address (row, then column)
//   RASA       : row address strobe
//   CASA0/1    : column strobes for the lower / upper byte lane
//   DTACK_DRAM : data acknowledge to the CPU
module dram_ctrl
  import dram_ctrl_pkg::*;
#(
  parameter int REFRESH_INTERVAL = DEF_REFRESH_INTERVAL,
  parameter int T_RP             = DEF_T_RP,
  parameter int T_RAS_REF        = DEF_T_RAS_REF
) (
  input  logic                   CLK_ALT,
  input  logic                   RST,
  input  logic                   CS,
  input  logic                   AS,
  input  logic                   LDS,
  input  logic                   UDS,
  input  logic                   RW,
  input  logic [23:1]            ADDR_IN,
  output logic [DRAM_ADDR_W-1:0] ADDR_OUT,
  output logic                   RASA,
  output logic                   CASA0,
  output logic                   CASA1,
  output logic                   DTACK_DRAM
);

  localparam int CNT_W = 8;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic                   ref_due;
  logic                   ref_clear;
  logic                   req;
  logic [DRAM_ADDR_W-1:0] row, col;
  logic [DRAM_ADDR_W-1:0] addr_d;
  logic                   rasa_d, casa0_d, casa1_d, dtack_d;

  logic unused_bits;
  assign unused_bits = ^{RW, ADDR_IN[23]};

  assign row = ADDR_IN[ROW_MSB:ROW_LSB];
  assign col = ADDR_IN[COL_MSB:COL_LSB];

  // Waiting for a data strobe as well as AS delays write cycles until the
  // strobes arrive, one clock after AS.
  assign req = ~CS & ~AS & (~LDS | ~UDS);

  dram_refresh_timer #(
    .REFRESH_INTERVAL(REFRESH_INTERVAL)
  ) u_refresh_timer (
    .clk  (CLK_ALT),
    .rst  (RST),
    .clear(ref_clear),
    .due  (ref_due)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ref_clear = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ref_due) begin
          state_d   = ST_REF_CAS;
          ref_clear = 1'b1;
        end else if (req) begin
          state_d = ST_A_RAS;
        end
      end
      ST_A_RAS: state_d = ST_A_COL;
      ST_A_COL: state_d = ST_A_CAS;
      ST_A_CAS: begin
        if (AS) begin
          state_d = ST_PRE;
          cnt_d   = '0;
        end
      end
      ST_REF_CAS: begin
        state_d = ST_REF_RAS;
        cnt_d   = '0;
      end
      ST_REF_RAS: begin
        if (cnt_q == CNT_W'(T_RAS_REF - 1)) begin
          state_d = ST_PRE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_PRE: begin
        if (cnt_q == CNT_W'(T_RP - 1)) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being
    // entered: RASA falls on the same edge that accepts the request.
    rasa_d  = 1'b1;
    casa0_d = 1'b1;
    casa1_d = 1'b1;
    dtack_d = 1'b1;
    addr_d  = row;

    case (state_d)
      ST_A_RAS: rasa_d = 1'b0;
      ST_A_COL: begin
        rasa_d = 1'b0;
        addr_d = col;
      end
      ST_A_CAS: begin
        rasa_d  = 1'b0;
        addr_d  = col;
        dtack_d = 1'b0;
        // Byte lanes are captured on entry and held for the whole access
        casa0_d = (state_q == ST_A_CAS) ? CASA0 : LDS;
        casa1_d = (state_q == ST_A_CAS) ? CASA1 : UDS;
      end
      ST_REF_CAS: begin
        casa0_d = 1'b0;
        casa1_d = 1'b0;
      end
      ST_REF_RAS: begin
        rasa_d  = 1'b0;
        casa0_d = 1'b0;
        casa1_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK_ALT) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      ADDR_OUT   <= '0;
      RASA       <= 1'b1;
      CASA0      <= 1'b1;
      CASA1      <= 1'b1;
      DTACK_DRAM <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ADDR_OUT   <= addr_d;
      RASA       <= rasa_d;
      CASA0      <= casa0_d;
      CASA1      <= casa1_d;
      DTACK_DRAM <= dtack_d;
    end
  end

endmodule

// File: tb/tb_dram_ctrl.sv
// Bench for dram_ctrl: a cycle-level behavioural model of the bus/refresh
// protocol is compared against the DUT outputs on every falling edge, plus
// hand-computed literal expectations for the directed scenarios.
module tb_dram_ctrl;

  localparam int RI  = 780;
  localparam int TRP = 2;
  localparam int TRR = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs = 1'b1, addr_strobe = 1'b1, lds = 1'b1, uds = 1'b1, rw = 1'b1;
  logic [23:1] addr_in = '0;

  logic [10:0] addr_out;
  logic        rasa, casa0, casa1, dtack;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #10 clk = ~clk;

  dram_ctrl #(
    .REFRESH_INTERVAL(RI),
    .T_RP(TRP),
    .T_RAS_REF(TRR)
  ) dut (
    .CLK_ALT   (clk),
    .RST       (rst),
    .CS        (cs),
    .AS        (addr_strobe),
    .LDS       (lds),
    .UDS       (uds),
    .RW        (rw),
    .ADDR_IN   (addr_in),
    .ADDR_OUT  (addr_out),
    .RASA      (rasa),
    .CASA0     (casa0),
    .CASA1     (casa1),
    .DTACK_DRAM(dtack)
  );

  // ---------------- behavioural model ----------------
  // activity: 0 idle, 1 access, 2 refresh, 3 precharge; step = clocks spent
  int   m_t;
  bit   m_pend;
  int   m_act, m_step;
  bit   m_l, m_u;
  logic e_ras, e_c0, e_c1, e_dt;
  logic [10:0] e_addr;

  always @(posedge clk) begin
    bit due, req;
    if (rst) begin
      m_t = 0; m_pend = 0; m_act = 0; m_step = 0;
      e_ras = 1; e_c0 = 1; e_c1 = 1; e_dt = 1; e_addr = '0;
    end else begin
      m_t++;
      due = m_pend || (m_t % RI == 0);
      if (m_t % RI == 0) m_pend = 1;
      req = !cs && !addr_strobe && (!lds || !uds);
      case (m_act)
        0: if (due) begin m_act = 2; m_step = 0; m_pend = 0; end
           else if (req) begin m_act = 1; m_step = 0; end
        1: if (m_step < 2) begin
             m_step++;
             if (m_step == 2) begin m_l = lds; m_u = uds; end
           end else if (addr_strobe) begin m_act = 3; m_step = 0; end
        2: begin m_step++; if (m_step == 1 + TRR) begin m_act = 3; m_step = 0; end end
        default: begin m_step++; if (m_step == TRP) begin m_act = 0; m_step = 0; end end
      endcase
      e_ras = 1; e_c0 = 1; e_c1 = 1; e_dt = 1; e_addr = addr_in[22:12];
      if (m_act == 1) begin
        e_ras = 0;
        if (m_step >= 1) e_addr = addr_in[11:1];
        if (m_step >= 2) begin e_c0 = m_l; e_c1 = m_u; e_dt = 0; end
      end else if (m_act == 2) begin
        e_c0 = 0; e_c1 = 0;
        if (m_step >= 1) e_ras = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if ({rasa, casa0, casa1, dtack, addr_out} !== {e_ras, e_c0, e_c1, e_dt, e_addr}) begin
        errors++;
        $display("FAIL model_cmp t=%0d got ras=%b cas0=%b cas1=%b dtack=%b addr=%h expected ras=%b cas0=%b cas1=%b dtack=%b addr=%h",
                 m_t, rasa, casa0, casa1, dtack, addr_out, e_ras, e_c0, e_c1, e_dt, e_addr);
      end
    end
  end

  // CBR refresh edges: CAS falls while RAS is still high
  int   ref_falls = 0;
  logic prev_c0 = 1'b1;
  always @(negedge clk) begin
    if (chk_en && prev_c0 === 1'b1 && casa0 === 1'b0 && rasa === 1'b1) ref_falls++;
    prev_c0 = casa0;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h (t=%0d)", name, got, exp, m_t);
    end
  endtask

  task automatic release_bus();
    addr_strobe = 1; lds = 1; uds = 1; cs = 1; rw = 1;
  endtask

  // Access started from idle with no refresh in the way; checks each edge.
  task automatic lit_access(input string nm, input logic [23:1] a, input logic l,
                            input logic u, input bit wr, input logic [10:0] xrow,
                            input logic [10:0] xcol);
    @(negedge clk);
    addr_in = a; rw = !wr; cs = 0; addr_strobe = 0;
    if (!wr) begin lds = l; uds = u; end
    if (wr) begin
      @(negedge clk);
      chk({nm, "_no_ras_before_strobe"}, rasa, 1);
      lds = l; uds = u;
    end
    @(negedge clk);
    chk({nm, "_ras"}, rasa, 0);
    chk({nm, "_row"}, addr_out, xrow);
    @(negedge clk);
    chk({nm, "_col"}, addr_out, xcol);
    chk({nm, "_cas_late"}, {casa0, casa1, dtack}, 3'b111);
    @(negedge clk);
    chk({nm, "_cas"}, {casa0, casa1, dtack}, {l, u, 1'b0});
    repeat (6) @(negedge clk);
    release_bus();
    @(negedge clk);
    chk({nm, "_release"}, {rasa, casa0, casa1, dtack}, 4'b1111);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_t(input int target);
    int n = 0;
    while (m_t != target && n < 3000) begin @(negedge clk); n++; end
    chk("wait_t_bound", (m_t == target), 1);
  endtask

  task automatic rand_access();
    logic [23:1] a;
    bit wr, nocs;
    int lane, n;
    logic l, u;
    a = 23'($urandom);
    wr = 1'($urandom_range(0, 1));
    nocs = ($urandom_range(0, 7) == 0);
    lane = $urandom_range(0, 2);
    l = (lane == 2); u = (lane == 1);
    @(negedge clk);
    addr_in = a; rw = !wr; cs = nocs; addr_strobe = 0;
    if (!wr) begin lds = l; uds = u; end
    if (wr) begin @(negedge clk); lds = l; uds = u; end
    if (nocs) begin
      repeat (3) @(negedge clk);
    end else begin
      n = 0;
      while (dtack !== 1'b0 && n < 40) begin @(negedge clk); n++; end
      chk("dtack_timeout", (n < 40), 1);
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end
    release_bus();
    repeat ($urandom_range(0, 4)) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r0, d, n;
    @(posedge clk);
    #1 chk_en = 1;
    repeat (5) @(negedge clk);
    chk("reset_strobes", {rasa, casa0, casa1, dtack}, 4'b1111);
    chk("reset_addr", addr_out, 0);
    rst = 0;

    lit_access("read16", 23'h09001A, 0, 0, 0, 11'h120, 11'h01A);
    lit_access("byte_lo", 23'h3FFFFF, 0, 1, 0, 11'h7FF, 11'h7FF);
    lit_access("byte_hi", 23'h55E6F0, 1, 0, 0, 11'h2BC, 11'h6F0);
    lit_access("write16", 23'h09001A, 0, 0, 1, 11'h120, 11'h01A);

    // Request lands on the edge the first refresh falls due
    wait_t(RI - 1);
    chk("no_refresh_before_interval", ref_falls, 0);
    addr_in = 23'h09001A; rw = 1; cs = 0; addr_strobe = 0; lds = 0; uds = 0;
    @(negedge clk);
    chk("collide_ref_cas", {rasa, casa0, casa1, dtack}, 4'b1001);
    repeat (6) @(negedge clk);
    chk("collide_precharge_done", {rasa, dtack}, 2'b11);
    @(negedge clk);
    chk("collide_access_ras", {rasa, casa0, dtack}, 3'b011);
    repeat (2) @(negedge clk);
    chk("collide_access_dtack", dtack, 0);
    release_bus();
    repeat (4) @(negedge clk);

    // Idle refresh rate over 1 ms at 50 MHz
    r0 = ref_falls;
    repeat (50000) @(negedge clk);
    d = ref_falls - r0;
    checks++;
    if (d < 63 || d > 65) begin
      errors++;
      $display("FAIL idle_refresh_count got=%0d expected=64+-1", d);
    end

    for (int i = 0; i < 300; i++) rand_access();

    // Reset in the middle of an access
    @(negedge clk);
    addr_in = 23'h09001A; cs = 0; addr_strobe = 0; lds = 0; uds = 0;
    n = 0;
    while (dtack !== 1'b0 && n < 40) begin @(negedge clk); n++; end
    chk("midreset_dtack_seen", (n < 40), 1);
    rst = 1;
    @(negedge clk);
    chk("midreset_strobes", {rasa, casa0, casa1, dtack}, 4'b1111);
    chk("midreset_addr", addr_out, 0);
    release_bus();
    rst = 0;
    repeat (10) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
